// File: rtl/ring_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ring_port_arbiter
//  Purpose  : Output-port stage of a ring router. It drains two upstream
//             depth-1 buffers (ring-through and local PE injection) with a
//             round-robin arbiter and writes one packet per grant into the
//             downstream link buffer. Ring-through packets have their
//             hop-count field decremented on the way through. A hop count
//             that is already zero saturates at zero and raises a sticky
//             error flag. Injected packets pass through unchanged.
//  Ports    : clk, reset      - clock, synchronous active-high reset
//             ring_empty/data - ring-through buffer status and read data
//             ring_rd         - ring-through buffer read enable
//             pe_empty/data   - PE injection buffer status and read data
//             pe_rd           - PE injection buffer read enable
//             out_full        - downstream link buffer full flag
//             out_wr/out_data - downstream write enable and packet
//             fwd_count       - saturating count of packets written
//             hop_err         - sticky: ring packet arrived with hop 0
//  Revision : 1.0 - initial release
// ============================================================================
module ring_port_arbiter #(
    parameter int WIDTH   = 64,
    parameter int HOP_LSB = 48,
    parameter int HOP_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ring_empty,
    input  logic [WIDTH-1:0] ring_data,
    output logic             ring_rd,
    input  logic             pe_empty,
    input  logic [WIDTH-1:0] pe_data,
    output logic             pe_rd,
    input  logic             out_full,
    output logic             out_wr,
    output logic [WIDTH-1:0] out_data,
    output logic [15:0]      fwd_count,
    output logic             hop_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } state_t;

    localparam logic SRC_RING = 1'b0;
    localparam logic SRC_PE   = 1'b1;

    state_t             r_state;
    logic               r_prio;        // 0: ring preferred, 1: PE preferred
    logic               r_grant_src;
    logic [WIDTH-1:0]   r_out_data;
    logic [15:0]        r_fwd_count;
    logic               r_hop_err;

    logic               w_issue;
    logic               w_ring_req;
    logic               w_pe_req;
    logic               w_ring_win;
    logic               w_pe_win;
    logic               w_send_ok;
    logic [HOP_W-1:0]   w_ring_hop;
    logic               w_hop_zero;
    logic [WIDTH-1:0]   w_ring_fwd;

    // Arbitration and handshake strobes. A SEND cycle that writes is also an
    // issue point, so the next read overlaps the current write and the port
    // sustains one packet every two cycles.
    always_comb begin
        w_ring_req = ~ring_empty;
        w_pe_req   = ~pe_empty;
        w_send_ok  = (r_state == SEND) && !out_full;
        w_issue    = (r_state == IDLE) || w_send_ok;
        w_ring_win = w_ring_req && (!w_pe_req || (r_prio == 1'b0));
        w_pe_win   = w_pe_req   && (!w_ring_req || (r_prio == 1'b1));

        // Strobes are gated by reset so nothing is read or written while the
        // port is being cleared.
        ring_rd    = !reset && w_issue && w_ring_win;
        pe_rd      = !reset && w_issue && w_pe_win;
        out_wr     = !reset && w_send_ok;
    end

    // Ring forwarding: decrement a nonzero hop count. A zero hop count is
    // forwarded as zero rather than wrapping to all-ones.
    always_comb begin
        w_ring_hop = ring_data[HOP_LSB +: HOP_W];
        w_hop_zero = (w_ring_hop == '0);
        w_ring_fwd = ring_data;
        if (!w_hop_zero) begin
            w_ring_fwd[HOP_LSB +: HOP_W] = w_ring_hop - HOP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_prio      <= 1'b0;
            r_grant_src <= SRC_RING;
            r_out_data  <= '0;
            r_fwd_count <= '0;
            r_hop_err   <= 1'b0;
        end else begin
            if (w_send_ok && (r_fwd_count != 16'hFFFF)) begin
                r_fwd_count <= r_fwd_count + 16'd1;
            end

            case (r_state)
                IDLE, SEND: begin
                    if (w_issue) begin
                        if (w_ring_win || w_pe_win) begin
                            r_grant_src <= w_pe_win ? SRC_PE : SRC_RING;
                            r_state     <= FETCH;
                            // On contention the loser becomes preferred next.
                            if (w_ring_req && w_pe_req) begin
                                r_prio <= ~r_prio;
                            end
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    // SEND with out_full high: hold state and data.
                end
                FETCH: begin
                    if (r_grant_src == SRC_RING) begin
                        r_out_data <= w_ring_fwd;
                        if (w_hop_zero) begin
                            r_hop_err <= 1'b1;
                        end
                    end else begin
                        r_out_data <= pe_data;
                    end
                    r_state <= SEND;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign fwd_count = r_fwd_count;
    assign hop_err   = r_hop_err;

endmodule
`default_nettype wire

// File: tb/tb_ring_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ring_port_arbiter
//  Purpose  : Directed self-checking bench for ring_port_arbiter. Upstream
//             buffers are modelled as small FIFOs with registered read data;
//             a monitor logs every read strobe and every downstream write.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ring_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        out_full = 1'b0;
    logic [63:0] ring_data;
    logic [63:0] pe_data;
    logic        ring_empty;
    logic        pe_empty;
    logic        ring_rd;
    logic        pe_rd;
    logic        out_wr;
    logic [63:0] out_data;
    logic [15:0] fwd_count;
    logic        hop_err;

    int checks = 0;
    int errors = 0;

    // Upstream buffer models: pushes come from the stimulus, pops from reads.
    logic [63:0] ring_mem [0:15];
    logic [63:0] pe_mem   [0:15];
    int ring_pushed = 0;
    int ring_popped = 0;
    int pe_pushed   = 0;
    int pe_popped   = 0;

    assign ring_empty = (ring_pushed == ring_popped);
    assign pe_empty   = (pe_pushed == pe_popped);

    // Monitor logs.
    int          cyc = 0;
    int          wr_n = 0;
    int          rd_n = 0;
    int          both_rd_cnt = 0;
    logic [63:0] wr_data_log [0:63];
    int          wr_cyc_log  [0:63];
    int          rd_src_log  [0:63];
    int          rd_cyc_log  [0:63];

    ring_port_arbiter #(
        .WIDTH   (64),
        .HOP_LSB (48),
        .HOP_W   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ring_empty (ring_empty),
        .ring_data  (ring_data),
        .ring_rd    (ring_rd),
        .pe_empty   (pe_empty),
        .pe_data    (pe_data),
        .pe_rd      (pe_rd),
        .out_full   (out_full),
        .out_wr     (out_wr),
        .out_data   (out_data),
        .fwd_count  (fwd_count),
        .hop_err    (hop_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ring_rd) begin
            ring_data              <= ring_mem[ring_popped % 16];
            ring_popped            <= ring_popped + 1;
            rd_src_log[rd_n % 64]  <= 0;
            rd_cyc_log[rd_n % 64]  <= cyc + 1;
            rd_n                   <= rd_n + 1;
        end
        if (pe_rd) begin
            pe_data                <= pe_mem[pe_popped % 16];
            pe_popped              <= pe_popped + 1;
            rd_src_log[rd_n % 64]  <= 1;
            rd_cyc_log[rd_n % 64]  <= cyc + 1;
            rd_n                   <= rd_n + 1;
        end
        if (ring_rd && pe_rd) begin
            both_rd_cnt <= both_rd_cnt + 1;
        end
        if (out_wr) begin
            wr_data_log[wr_n % 64] <= out_data;
            wr_cyc_log[wr_n % 64]  <= cyc + 1;
            wr_n                   <= wr_n + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic push_ring(input logic [63:0] pkt);
        ring_mem[ring_pushed % 16] = pkt;
        ring_pushed = ring_pushed + 1;
    endtask

    task automatic push_pe(input logic [63:0] pkt);
        pe_mem[pe_pushed % 16] = pkt;
        pe_pushed = pe_pushed + 1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        out_full = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Bounded wait for n writes beyond base; an expired bound counts as a failure.
    task automatic wait_writes(input int base, input int n, input int budget, input string name);
        int k;
        k = 0;
        while (((wr_n - base) < n) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if ((wr_n - base) < n) begin
            errors++;
            $display("FAIL %s timeout: writes=%0d required=%0d", name, wr_n - base, n);
        end
    endtask

    task automatic test_reset();
        int base;
        reset = 1'b1;
        push_ring(64'h0001_0000_0000_0055);
        repeat (2) @(negedge clk);
        checks++;
        if (ring_rd !== 1'b0 || pe_rd !== 1'b0 || out_wr !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: ring_rd=%b pe_rd=%b out_wr=%b required 0 0 0", ring_rd, pe_rd, out_wr);
        end
        checks++;
        if (out_data !== 64'h0 || fwd_count !== 16'h0 || hop_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: out_data=%h fwd_count=%h hop_err=%b required 0 0 0", out_data, fwd_count, hop_err);
        end
        base = wr_n;
        reset = 1'b0;
        wait_writes(base, 1, 10, "reset_drain");
        checks++;
        if (wr_data_log[base % 64] !== 64'h0000_0000_0000_0055 || hop_err !== 1'b0) begin
            errors++;
            $display("FAIL hop_one: data=%h hop_err=%b required 0000000000000055 0", wr_data_log[base % 64], hop_err);
        end
    endtask

    task automatic test_single();
        int base_wr, base_rd, t0;
        apply_reset();
        base_wr = wr_n;
        base_rd = rd_n;
        t0 = cyc;
        push_ring(64'h0005_0000_0000_00AA);
        wait_writes(base_wr, 1, 10, "single");
        checks++;
        if (wr_data_log[base_wr % 64] !== 64'h0004_0000_0000_00AA) begin
            errors++;
            $display("FAIL single_data: got %h required 00040000000000aa", wr_data_log[base_wr % 64]);
        end
        checks++;
        if (rd_src_log[base_rd % 64] !== 0 || rd_cyc_log[base_rd % 64] !== t0 + 1) begin
            errors++;
            $display("FAIL single_rd: src=%0d cycle=%0d required src 0 cycle %0d",
                     rd_src_log[base_rd % 64], rd_cyc_log[base_rd % 64] - t0, 1);
        end
        checks++;
        if (wr_cyc_log[base_wr % 64] !== t0 + 3) begin
            errors++;
            $display("FAIL single_latency: write cycle %0d required 3", wr_cyc_log[base_wr % 64] - t0);
        end
        checks++;
        if (fwd_count !== 16'd1 || hop_err !== 1'b0) begin
            errors++;
            $display("FAIL single_count: fwd_count=%0d hop_err=%b required 1 0", fwd_count, hop_err);
        end
    endtask

    task automatic test_back_to_back();
        int base_wr;
        logic [63:0] exp;
        apply_reset();
        base_wr = wr_n;
        for (int k = 0; k < 4; k++) begin
            push_ring(64'h0003_0000_0000_0000 | 64'(k + 16));
            push_pe(64'h00C0_0000_0000_0000 | 64'(k + 32));
        end
        wait_writes(base_wr, 8, 40, "b2b");
        for (int i = 0; i < 8; i++) begin
            if ((i % 2) == 0) exp = 64'h0002_0000_0000_0000 | 64'(i / 2 + 16);
            else              exp = 64'h00C0_0000_0000_0000 | 64'(i / 2 + 32);
            checks++;
            if (wr_data_log[(base_wr + i) % 64] !== exp) begin
                errors++;
                $display("FAIL b2b_order[%0d]: got %h required %h", i, wr_data_log[(base_wr + i) % 64], exp);
            end
            if (i > 0) begin
                checks++;
                if (wr_cyc_log[(base_wr + i) % 64] - wr_cyc_log[(base_wr + i - 1) % 64] !== 2) begin
                    errors++;
                    $display("FAIL b2b_gap[%0d]: got %0d cycles required 2", i,
                             wr_cyc_log[(base_wr + i) % 64] - wr_cyc_log[(base_wr + i - 1) % 64]);
                end
            end
        end
        checks++;
        if (fwd_count !== 16'd8) begin
            errors++;
            $display("FAIL b2b_count: got %0d required 8", fwd_count);
        end
    endtask

    task automatic test_backpressure();
        int base_wr;
        logic [63:0] pkt;
        pkt = 64'h00FF_1234_5678_9ABC;
        apply_reset();
        out_full = 1'b1;
        base_wr = wr_n;
        push_pe(pkt);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_wr !== 1'b0 || out_data !== pkt) begin
                errors++;
                $display("FAIL bp_hold[%0d]: out_wr=%b out_data=%h required 0 %h", i, out_wr, out_data, pkt);
            end
            @(negedge clk);
        end
        out_full = 1'b0;
        #1;
        checks++;
        if (out_wr !== 1'b1 || out_data !== pkt) begin
            errors++;
            $display("FAIL bp_release: out_wr=%b out_data=%h required 1 %h", out_wr, out_data, pkt);
        end
        repeat (4) @(negedge clk);
        checks++;
        if ((wr_n - base_wr) !== 1 || fwd_count !== 16'd1) begin
            errors++;
            $display("FAIL bp_single: writes=%0d fwd_count=%0d required 1 1", wr_n - base_wr, fwd_count);
        end
    endtask

    task automatic test_hop_zero();
        int base_wr;
        apply_reset();
        base_wr = wr_n;
        push_ring(64'h1100_0000_0000_0011);
        wait_writes(base_wr, 1, 10, "hop0");
        checks++;
        if (wr_data_log[base_wr % 64] !== 64'h1100_0000_0000_0011 || hop_err !== 1'b1) begin
            errors++;
            $display("FAIL hop0_fwd: data=%h hop_err=%b required 1100000000000011 1", wr_data_log[base_wr % 64], hop_err);
        end
        push_ring(64'h0002_0000_0000_0022);
        wait_writes(base_wr, 2, 10, "hop0_next");
        checks++;
        if (wr_data_log[(base_wr + 1) % 64] !== 64'h0001_0000_0000_0022 || hop_err !== 1'b1) begin
            errors++;
            $display("FAIL hop0_sticky: data=%h hop_err=%b required 0001000000000022 1",
                     wr_data_log[(base_wr + 1) % 64], hop_err);
        end
        apply_reset();
        checks++;
        if (hop_err !== 1'b0) begin
            errors++;
            $display("FAIL hop0_clear: hop_err=%b required 0", hop_err);
        end
    endtask

    task automatic test_reset_mid();
        int base_wr, base_rd;
        apply_reset();
        out_full = 1'b1;
        push_ring(64'h0004_0000_0000_0033);
        push_pe(64'h0000_0000_0000_0044);
        repeat (2) @(negedge clk);
        // Ring packet now waits in SEND; PE packet still pending upstream.
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (out_wr !== 1'b0 || ring_rd !== 1'b0 || pe_rd !== 1'b0) begin
            errors++;
            $display("FAIL mid_strobes: out_wr=%b ring_rd=%b pe_rd=%b required 0 0 0", out_wr, ring_rd, pe_rd);
        end
        checks++;
        if (out_data !== 64'h0 || fwd_count !== 16'h0) begin
            errors++;
            $display("FAIL mid_clear: out_data=%h fwd_count=%0d required 0 0", out_data, fwd_count);
        end
        reset = 1'b0;
        out_full = 1'b0;
        base_wr = wr_n;
        base_rd = rd_n;
        push_ring(64'h0007_0000_0000_0066);
        @(negedge clk);
        checks++;
        if ((rd_n - base_rd) !== 1 || rd_src_log[base_rd % 64] !== 0) begin
            errors++;
            $display("FAIL mid_prio: reads=%0d src=%0d required 1 0", rd_n - base_rd, rd_src_log[base_rd % 64]);
        end
        wait_writes(base_wr, 2, 20, "mid_drain");
        checks++;
        if (wr_data_log[base_wr % 64] !== 64'h0006_0000_0000_0066 ||
            wr_data_log[(base_wr + 1) % 64] !== 64'h0000_0000_0000_0044) begin
            errors++;
            $display("FAIL mid_order: got %h %h required 0006000000000066 0000000000000044",
                     wr_data_log[base_wr % 64], wr_data_log[(base_wr + 1) % 64]);
        end
    endtask

    task automatic test_saturate();
        int base_wr;
        apply_reset();
        force dut.r_fwd_count = 16'hFFFE;
        #1;
        release dut.r_fwd_count;
        base_wr = wr_n;
        for (int k = 0; k < 3; k++) push_pe(64'h0000_0000_0000_0100 | 64'(k));
        wait_writes(base_wr, 1, 10, "sat_first");
        checks++;
        if (fwd_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_first: got %h required ffff", fwd_count);
        end
        wait_writes(base_wr, 3, 20, "sat_all");
        checks++;
        if (fwd_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_hold: got %h required ffff", fwd_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_hop_zero();
        test_reset_mid();
        test_saturate();
        repeat (2) @(negedge clk);
        checks++;
        if (both_rd_cnt !== 0) begin
            errors++;
            $display("FAIL rd_exclusive: simultaneous reads=%0d required 0", both_rd_cnt);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
